// File: rtl/bpsk_frame_sequencer_if.sv
// Payload byte stream into the frame sequencer.
// The source holds s_data/s_valid; s_ready is a single-cycle accept strobe from the sink.
interface bpsk_frame_sequencer_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/bpsk_frame_sequencer.sv
// BPSK framer: preamble then payload bits MSB first, SPS_DIV cycles per symbol; outputs lag each tick by one cycle.
// Payload bytes are pulled with a one-cycle s_ready strobe; a missing byte aborts the frame (underrun) rather than stalling.
module bpsk_frame_sequencer #(
   parameter int unsigned SPS_DIV      = 4,
   parameter int unsigned PREAMBLE_LEN = 16,
   parameter logic [15:0] PREAMBLE_PAT = 16'hAAAA
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [7:0]                  payload_len,
   bpsk_frame_sequencer_if.slave       s_bus,
   output logic [3:0]                  sym_bit,
   output logic                        sym_stb,
   output logic                        tx_en,
   output logic                        busy,
   output logic                        done,
   output logic                        underrun
);

   typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(SPS_DIV - 1);
   localparam logic [4:0] PRE_LEN  = 5'(PREAMBLE_LEN);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [4:0] pre_left, pre_left_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] byte_cnt, byte_cnt_n;
   logic [6:0] shift, shift_n;
   logic       sym_q, sym_n;
   logic       stb_n, tx_n, ur_n;
   logic       rdy;
   logic       sym_end;
   logic [3:0] pre_bit;

   assign sym_end = (cnt == CNT_LAST);
   assign pre_bit = 4'(pre_left - 5'd1);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      pre_left_n = pre_left;
      bit_idx_n  = bit_idx;
      byte_cnt_n = byte_cnt;
      shift_n    = shift;
      sym_n      = sym_q;
      stb_n      = 1'b0;
      tx_n       = tx_en;
      ur_n       = 1'b0;
      rdy        = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = 8'd0;
            tx_n  = 1'b0;
            sym_n = 1'b0;
            if (start) begin
               state_n    = PREAMBLE;
               byte_cnt_n = payload_len;
               pre_left_n = PRE_LEN;
               bit_idx_n  = 3'd7;
            end
         end
         PREAMBLE: begin
            cnt_n = sym_end ? 8'd0 : cnt + 8'd1;
            if (cnt == 8'd0) begin
               sym_n      = PREAMBLE_PAT[pre_bit];
               stb_n      = 1'b1;
               tx_n       = 1'b1;
               pre_left_n = pre_left - 5'd1;
            end
            // pre_left reaches 0 only at the tick of the final preamble symbol
            if (sym_end && pre_left == 5'd0)
               state_n = (byte_cnt != 8'd0) ? PAYLOAD : DONE;
         end
         PAYLOAD: begin
            cnt_n = sym_end ? 8'd0 : cnt + 8'd1;
            if (cnt == 8'd0) begin
               stb_n     = 1'b1;
               tx_n      = 1'b1;
               bit_idx_n = bit_idx - 3'd1;
               if (bit_idx == 3'd7) begin
                  rdy = 1'b1;
                  if (s_bus.s_valid) begin
                     sym_n      = s_bus.s_data[7];
                     shift_n    = s_bus.s_data[6:0];
                     byte_cnt_n = byte_cnt - 8'd1;
                  end else begin
                     ur_n    = 1'b1;
                     stb_n   = 1'b0;
                     tx_n    = 1'b0;
                     sym_n   = 1'b0;
                     cnt_n   = 8'd0;
                     state_n = IDLE;
                  end
               end else begin
                  sym_n   = shift[6];
                  shift_n = {shift[5:0], 1'b0};
               end
            end
            // bit_idx back at 7 with no bytes left: the last bit has just finished its hold
            if (sym_end && bit_idx == 3'd7 && byte_cnt == 8'd0)
               state_n = DONE;
         end
         DONE: begin
            tx_n    = 1'b0;
            sym_n   = 1'b0;
            cnt_n   = 8'd0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         pre_left <= 5'd0;
         bit_idx  <= 3'd0;
         byte_cnt <= 8'd0;
         shift    <= 7'd0;
         sym_q    <= 1'b0;
         sym_stb  <= 1'b0;
         tx_en    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         pre_left <= pre_left_n;
         bit_idx  <= bit_idx_n;
         byte_cnt <= byte_cnt_n;
         shift    <= shift_n;
         sym_q    <= sym_n;
         sym_stb  <= stb_n;
         tx_en    <= tx_n;
         underrun <= ur_n;
      end
   end

   assign sym_bit       = {3'b000, sym_q};
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);
   assign s_bus.s_ready = rdy;

endmodule

// File: tb/tb_bpsk_frame_sequencer.sv
// Directed bench for bpsk_frame_sequencer: default build (A) and a short-preamble SPS_DIV=2 build (B).
module tb_bpsk_frame_sequencer;

   logic       clk = 1'b0;
   logic       a_rst, b_rst;
   logic       sel;
   logic       start_d;
   logic [7:0] len_d, data_d;
   logic       valid_d;

   logic [3:0] a_sym, b_sym;
   logic       a_stb, a_tx, a_busy, a_done, a_ur;
   logic       b_stb, b_tx, b_busy, b_done, b_ur;
   logic       a_start, b_start;

   logic [3:0] m_sym;
   logic       m_stb, m_tx, m_busy, m_done, m_ur, m_rdy;

   int checks = 0;
   int errors = 0;

   int res_tx, res_stb, res_rdy, res_dn, res_ur, res_first_tx, res_last_tx;
   int res_dn_i, res_ur_i, res_bad, res_timeout;
   logic [63:0] res_syms;

   always #5 clk = ~clk;

   bpsk_frame_sequencer_if a_bus ();
   bpsk_frame_sequencer_if b_bus ();

   assign a_start        = start_d & ~sel;
   assign b_start        = start_d & sel;
   assign a_bus.s_data   = data_d;
   assign b_bus.s_data   = data_d;
   assign a_bus.s_valid  = valid_d & ~sel;
   assign b_bus.s_valid  = valid_d & sel;

   assign m_sym  = sel ? b_sym  : a_sym;
   assign m_stb  = sel ? b_stb  : a_stb;
   assign m_tx   = sel ? b_tx   : a_tx;
   assign m_busy = sel ? b_busy : a_busy;
   assign m_done = sel ? b_done : a_done;
   assign m_ur   = sel ? b_ur   : a_ur;
   assign m_rdy  = sel ? b_bus.s_ready : a_bus.s_ready;

   bpsk_frame_sequencer dut_a (
      .clk         (clk),
      .rst         (a_rst),
      .start       (a_start),
      .payload_len (len_d),
      .s_bus       (a_bus),
      .sym_bit     (a_sym),
      .sym_stb     (a_stb),
      .tx_en       (a_tx),
      .busy        (a_busy),
      .done        (a_done),
      .underrun    (a_ur)
   );

   bpsk_frame_sequencer #(
      .SPS_DIV      (2),
      .PREAMBLE_LEN (1),
      .PREAMBLE_PAT (16'h0001)
   ) dut_b (
      .clk         (clk),
      .rst         (b_rst),
      .start       (b_start),
      .payload_len (len_d),
      .s_bus       (b_bus),
      .sym_bit     (b_sym),
      .sym_stb     (b_stb),
      .tx_en       (b_tx),
      .busy        (b_busy),
      .done        (b_done),
      .underrun    (b_ur)
   );

   // Starts one frame and records what it produced; drop_byte is the payload byte index withheld (-1 = none),
   // restart_at is the cycle on which a second start is pulsed (-1 = never).
   task automatic run_frame(input logic use_b, input int len, input int drop_byte,
                            input int restart_at, input int max_cyc);
      int   i;
      int   k;
      logic pend;
      logic fin;
      sel = use_b;
      res_tx = 0; res_stb = 0; res_rdy = 0; res_dn = 0; res_ur = 0;
      res_first_tx = 0; res_last_tx = 0; res_dn_i = 0; res_ur_i = 0;
      res_bad = 0; res_timeout = 0; res_syms = '0;
      @(negedge clk);
      start_d = 1'b1;
      len_d   = 8'(len);
      data_d  = 8'hC3;
      valid_d = (drop_byte != 0);
      i = 0; k = 0; pend = 1'b0; fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         i++;
         start_d = 1'b0;
         if (i == restart_at) begin
            start_d = 1'b1;
            len_d   = 8'd3;
         end
         if (pend) begin
            valid_d = (k != drop_byte);
            pend    = 1'b0;
         end
         if (m_rdy) begin
            res_rdy++;
            if (valid_d) k++;
            pend = 1'b1;
         end
         if (m_tx) begin
            res_tx++;
            if (res_first_tx == 0) res_first_tx = i;
            res_last_tx = i;
         end
         if (m_stb) begin
            res_stb++;
            res_syms = {res_syms[62:0], m_sym[0]};
            if (m_sym[3:1] != 3'b000) res_bad++;
         end
         if (m_done) begin res_dn++; res_dn_i = i; end
         if (m_ur)   begin res_ur++; res_ur_i = i; end
         if (!m_busy) fin = 1'b1;
         if (i >= max_cyc) begin res_timeout = 1; fin = 1'b1; end
      end
      valid_d = 1'b0;
   endtask

   task automatic test_reset;
      logic [9:0] a_outs, b_outs;
      a_rst = 1'b1; b_rst = 1'b1;
      sel = 1'b0; start_d = 1'b1; len_d = 8'd1; data_d = 8'hC3; valid_d = 1'b1;
      repeat (3) @(negedge clk);
      a_outs = {a_sym, a_stb, a_tx, a_busy, a_done, a_ur, a_bus.s_ready};
      b_outs = {b_sym, b_stb, b_tx, b_busy, b_done, b_ur, b_bus.s_ready};
      checks++;
      if (a_outs !== 10'd0) begin errors++; $display("FAIL reset_outputs_a: got %b expected %b", a_outs, 10'd0); end
      checks++;
      if (b_outs !== 10'd0) begin errors++; $display("FAIL reset_outputs_b: got %b expected %b", b_outs, 10'd0); end
      start_d = 1'b0; valid_d = 1'b0;
      a_rst = 1'b0; b_rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", a_busy); end
   endtask

   task automatic test_basic;
      run_frame(1'b0, 1, -1, -1, 400);
      checks++;
      if (res_timeout !== 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", res_timeout); end
      checks++;
      if (res_tx !== 96) begin errors++; $display("FAIL basic_tx_cycles: got %0d expected 96", res_tx); end
      checks++;
      if (res_stb !== 24) begin errors++; $display("FAIL basic_stb_count: got %0d expected 24", res_stb); end
      checks++;
      if (res_syms[23:0] !== 24'hAAAAC3) begin errors++; $display("FAIL basic_symbols: got %h expected aaaac3", res_syms[23:0]); end
      checks++;
      if (res_rdy !== 1) begin errors++; $display("FAIL basic_ready_count: got %0d expected 1", res_rdy); end
      checks++;
      if (res_dn !== 1 || res_dn_i !== 97) begin errors++; $display("FAIL basic_done: got %0d at %0d expected 1 at 97", res_dn, res_dn_i); end
      checks++;
      if (res_first_tx !== 2 || res_last_tx !== 97) begin errors++; $display("FAIL basic_tx_window: got %0d..%0d expected 2..97", res_first_tx, res_last_tx); end
      checks++;
      if (res_ur !== 0 || res_bad !== 0) begin errors++; $display("FAIL basic_no_underrun_code: got ur=%0d bad=%0d expected 0 0", res_ur, res_bad); end
      checks++;
      if (m_sym !== 4'd0 || m_tx !== 1'b0) begin errors++; $display("FAIL basic_idle_outputs: got sym=%b tx=%b expected 0000 0", m_sym, m_tx); end
   endtask

   task automatic test_zero_len;
      run_frame(1'b0, 0, -1, -1, 300);
      checks++;
      if (res_tx !== 64 || res_timeout !== 0) begin errors++; $display("FAIL zero_tx_cycles: got %0d expected 64", res_tx); end
      checks++;
      if (res_stb !== 16 || res_syms[15:0] !== 16'hAAAA) begin errors++; $display("FAIL zero_symbols: got %0d/%h expected 16/aaaa", res_stb, res_syms[15:0]); end
      checks++;
      if (res_rdy !== 0) begin errors++; $display("FAIL zero_ready: got %0d expected 0", res_rdy); end
      checks++;
      if (res_dn !== 1 || res_dn_i !== 65) begin errors++; $display("FAIL zero_done: got %0d at %0d expected 1 at 65", res_dn, res_dn_i); end
   endtask

   task automatic test_underrun;
      run_frame(1'b0, 2, 1, -1, 400);
      checks++;
      if (res_stb !== 24 || res_syms[23:0] !== 24'hAAAAC3) begin errors++; $display("FAIL ur_symbols: got %0d/%h expected 24/aaaac3", res_stb, res_syms[23:0]); end
      checks++;
      if (res_ur !== 1 || res_ur_i !== 98) begin errors++; $display("FAIL ur_pulse: got %0d at %0d expected 1 at 98", res_ur, res_ur_i); end
      checks++;
      if (res_last_tx !== 97 || res_tx !== 96) begin errors++; $display("FAIL ur_tx_fall: got last %0d count %0d expected 97 96", res_last_tx, res_tx); end
      checks++;
      if (res_dn !== 0) begin errors++; $display("FAIL ur_no_done: got %0d expected 0", res_dn); end
      checks++;
      if (res_rdy !== 2) begin errors++; $display("FAIL ur_ready_count: got %0d expected 2", res_rdy); end
   endtask

   task automatic test_back_to_back;
      run_frame(1'b0, 1, -1, 10, 400);
      checks++;
      if (res_tx !== 96 || res_stb !== 24) begin errors++; $display("FAIL restart_ignored: got tx %0d stb %0d expected 96 24", res_tx, res_stb); end
      checks++;
      if (res_dn !== 1 || res_rdy !== 1) begin errors++; $display("FAIL restart_done: got done %0d rdy %0d expected 1 1", res_dn, res_rdy); end
      run_frame(1'b0, 0, -1, -1, 300);
      checks++;
      if (res_tx !== 64 || res_dn !== 1) begin errors++; $display("FAIL b2b_new_frame: got tx %0d done %0d expected 64 1", res_tx, res_dn); end
   endtask

   task automatic test_reset_mid;
      logic [9:0] outs;
      int pulses;
      pulses = 0;
      sel = 1'b0;
      @(negedge clk);
      start_d = 1'b1; len_d = 8'd2; data_d = 8'hC3; valid_d = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         start_d = 1'b0;
         if (a_done || a_ur) pulses++;
      end
      checks++;
      if ({a_busy, a_tx} !== 2'b11) begin errors++; $display("FAIL midrst_in_frame: got busy/tx %b%b expected 11", a_busy, a_tx); end
      a_rst = 1'b1;
      #1;
      outs = {a_sym, a_stb, a_tx, a_busy, a_done, a_ur, a_bus.s_ready};
      checks++;
      if (outs !== 10'd0) begin errors++; $display("FAIL midrst_outputs: got %b expected %b", outs, 10'd0); end
      repeat (2) begin
         @(negedge clk);
         if (a_done || a_ur) pulses++;
      end
      a_rst = 1'b0;
      valid_d = 1'b0;
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulses); end
      run_frame(1'b0, 1, -1, -1, 400);
      checks++;
      if (res_tx !== 96 || res_stb !== 24 || res_syms[23:0] !== 24'hAAAAC3) begin
         errors++; $display("FAIL midrst_new_frame: got tx %0d stb %0d sym %h expected 96 24 aaaac3", res_tx, res_stb, res_syms[23:0]);
      end
      checks++;
      if (res_dn !== 1) begin errors++; $display("FAIL midrst_done: got %0d expected 1", res_dn); end
   endtask

   task automatic test_long_frame;
      run_frame(1'b1, 255, -1, -1, 5000);
      checks++;
      if (res_timeout !== 0) begin errors++; $display("FAIL long_timeout: got %0d expected 0", res_timeout); end
      checks++;
      if (res_stb !== 2041) begin errors++; $display("FAIL long_stb_count: got %0d expected 2041", res_stb); end
      checks++;
      if (res_tx !== 4082) begin errors++; $display("FAIL long_tx_cycles: got %0d expected 4082", res_tx); end
      checks++;
      if (res_rdy !== 255) begin errors++; $display("FAIL long_ready_count: got %0d expected 255", res_rdy); end
      checks++;
      if (res_dn !== 1 || res_ur !== 0) begin errors++; $display("FAIL long_done: got done %0d ur %0d expected 1 0", res_dn, res_ur); end
      checks++;
      if (res_syms[15:0] !== 16'hC3C3) begin errors++; $display("FAIL long_tail_symbols: got %h expected c3c3", res_syms[15:0]); end
      checks++;
      if (res_first_tx !== 2) begin errors++; $display("FAIL long_first_tx: got %0d expected 2", res_first_tx); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_underrun();
      test_back_to_back();
      test_reset_mid();
      test_long_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
